sp_ram_arbiter: RTL
===================

Name: sp_ram_arbiter

Overview:
Two-master arbiter that shares one sp_ram instance between an instruction-fetch master (m0) and a data master (m1). It is a req/gnt/rvalid protocol multiplexer. Selection is round-robin with a lock that holds a master while the memory stalls. A small in-order owner FIFO routes each memory response back to the master that issued it. It sits between the core's two memory ports and the sp_ram slave port.

Parameters:
ADDR_WIDTH, 8, address width of masters and memory
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
MAX_OUTSTANDING, 2, depth of owner FIFO (granted, not yet responded transactions); must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_req_i / m1_req_i  in  1  master request
m0_addr_i / m1_addr_i  in  ADDR_WIDTH  address
m0_we_i / m1_we_i  in  1  write enable
m0_wdata_i / m1_wdata_i  in  DATA_WIDTH  write data
m0_be_i / m1_be_i  in  DATA_WIDTH/8  byte enables
m0_gnt_o / m1_gnt_o  out  1  grant to master
m0_rvalid_o / m1_rvalid_o  out  1  response valid to master
m0_rdata_o / m1_rdata_o  out  DATA_WIDTH  response data
mem_req_o  out  1  request to sp_ram
mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o  out  as master  muxed command
mem_gnt_i  in  1  sp_ram grant
mem_rvalid_i  in  1  sp_ram response valid (one per granted transaction, reads and writes)
mem_rdata_i  in  DATA_WIDTH  sp_ram read data
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n low): FIFO empty; priority pointer = m0; lock cleared; err_o = 0. All outputs are combinationally 0 while in reset and when idle.
- Selection (combinational):
  - Locked: selected master = locked owner.
  - Otherwise: the single requester wins. If both request, the master at the priority pointer wins.
- mem_req_o = selected master's req AND NOT fifo_full. Command fields are muxed from the selected master and are 0 when mem_req_o = 0.
- mX_gnt_o = mem_gnt_i AND mem_req_o AND (selected == X). Grant latency follows the memory: same cycle when sp_ram grants immediately.
- Handshake on mem_req_o & mem_gnt_i:
  - Push owner ID to the FIFO.
  - Priority pointer moves to the other master.
  - Lock clears.
- Stall on mem_req_o & !mem_gnt_i: lock = selected master for the next cycle. The lock releases if that master drops req (protocol violation; no error flagged).
- Responses:
  - On mem_rvalid_i with FIFO non-empty: pop the FIFO. Assert rvalid for the popped owner in the same cycle, with rdata = mem_rdata_i. The other master's rdata = 0.
  - Responses are returned strictly in order.
- Spurious response: mem_rvalid_i with FIFO empty sets err_o = 1 until reset. The response is discarded.
- Full FIFO: no new request is issued. A pop in the same cycle does not unblock until the next cycle, so mem_req_o depends only on registered fullness.
- Simultaneous push and pop when not full: both occur; occupancy is unchanged.
- Reset mid-operation: outstanding owners are dropped. Late memory responses after reset raise err_o.
- Width rules: the FIFO count register is clog2(MAX_OUTSTANDING+1) bits. Pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
1. Reset: rst_n low with m0_req_i = 1 -> mem_req_o = 0, both gnt/rvalid = 0, err_o = 0. After release, mem_req_o = 1 in the same cycle with mem_addr_o = m0_addr_i.
2. Single read: m0 reads addr 0x80, sp_ram preloaded -> m0_gnt_o high in cycle N. m0_rvalid_o high in N+1 with m0_rdata_o = mem[0x80]. m1 outputs stay 0.
3. Contention: both masters request continuously, m0 at 0x80, m1 writes 0xBEEF to 0xCC -> grants alternate m0, m1, m0, …. Each rvalid goes to the correct master. Reading back 0xCC returns 0x0000BEEF.
4. Stall lock: mem_gnt_i held low 3 cycles while m0 is selected; m1_req_i rises in stall cycle 1 -> mem_addr_o stays m0's address for all 3 cycles. m0 is granted first, m1 in the next cycle.
5. Outstanding limit: mem_rvalid_i delayed 4 cycles -> after 2 grants mem_req_o = 0. It reasserts the cycle after the first rvalid.
6. Error: mem_rvalid_i pulse with FIFO empty -> err_o = 1 and stays 1 through further traffic. rst_n low clears it to 0.

Source files
------------

// File: rtl/sp_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter_if
//
// One req/gnt/rvalid memory bus as used by sp_ram and the core's memory ports.
// The requester side (a core port, or the arbiter facing sp_ram) uses the
// master modport; the responder side (sp_ram, or the arbiter facing a core
// port) uses the slave modport.
//
// Signals:
//   req     master -> slave  command valid, held until gnt
//   addr    master -> slave  word address (ADDR_WIDTH)
//   we      master -> slave  1 = write, 0 = read
//   wdata   master -> slave  write data (DATA_WIDTH)
//   be      master -> slave  byte enables (DATA_WIDTH/8)
//   gnt     slave  -> master command accepted this cycle
//   rvalid  slave  -> master one response per accepted command, in order
//   rdata   slave  -> master read data, meaningful only with rvalid
// ---------------------------------------------------------------------------
interface sp_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      we;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   be;
    logic                      gnt;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output req, addr, we, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter
//
// Shares one sp_ram between the instruction-fetch port (m0) and the data
// port (m1) of the core.
//
//   * Round-robin selection between the two masters. A master that is
//     selected while sp_ram withholds gnt stays selected (locked) until it
//     is granted, so the command seen by sp_ram never changes mid-stall.
//   * An in-order owner FIFO remembers which master each granted command
//     belongs to, so every sp_ram response is steered back to its issuer.
//   * At most MAX_OUTSTANDING commands may be granted and still waiting for
//     their response; beyond that no request is issued.
//   * A response arriving while nothing is outstanding is dropped and sets
//     a sticky error flag.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   m0      slave modport   instruction-fetch master
//   m1      slave modport   data master
//   mem     master modport  towards sp_ram
//   err_o   out  sticky protocol error (spurious response), cleared by reset
//
// All outputs are 0 while rst_n is low and whenever there is nothing to
// issue or return.
// ---------------------------------------------------------------------------
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_arbiter_if.slave       m0,
    sp_ram_arbiter_if.slave       m1,
    sp_ram_arbiter_if.master      mem,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Lock state: which master (if any) is pinned because sp_ram stalled it.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'b00,
        LOCK_M0   = 2'b01,
        LOCK_M1   = 2'b10
    } lock_e;

    lock_e                 lock_q, lock_d;
    logic                  prio_q, prio_d;   // 0: m0 wins a tie, 1: m1 wins
    logic                  sel;              // 0: m0 selected, 1: m1 selected
    logic                  sel_req;
    logic                  issue;            // mem.req
    logic                  push;             // command handshake
    logic                  pop;              // response consumed

    // Owner FIFO
    logic [CNT_W-1:0]      cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  owner_mem [MAX_OUTSTANDING];
    logic                  fifo_full, fifo_empty;
    logic                  head_owner;

    // Pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Fullness comes from the registered count only: a response popping in
    // the same cycle does not open a slot until the next cycle, which keeps
    // mem.rvalid off the combinational path to mem.req.
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);
    assign head_owner = owner_mem[rd_ptr_q];

    // ------------------------------------------------------------------
    // Selection, issue and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven in this block is given a default first,
        // so no branch can leave one unassigned and infer a latch.
        sel     = prio_q;
        sel_req = 1'b0;
        issue   = 1'b0;
        push    = 1'b0;
        lock_d  = LOCK_NONE;
        prio_d  = prio_q;

        case (lock_q)
            LOCK_M0: sel = 1'b0;
            LOCK_M1: sel = 1'b1;
            default: begin
                // A lone requester wins; on a tie the priority pointer decides.
                if (m0.req && !m1.req) begin
                    sel = 1'b0;
                end else if (m1.req && !m0.req) begin
                    sel = 1'b1;
                end
            end
        endcase

        sel_req = sel ? m1.req : m0.req;
        issue   = rst_n && sel_req && !fifo_full;
        push    = issue && mem.gnt;

        if (push) begin
            // Granted: hand priority to the other master, lock stays clear.
            prio_d = ~sel;
        end else if (issue) begin
            // Stalled: keep this master selected next cycle. If it drops req
            // nothing is issued and the lock falls away on its own.
            lock_d = sel ? LOCK_M1 : LOCK_M0;
        end
    end

    assign pop = mem.rvalid && !fifo_empty;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= LOCK_NONE;
            prio_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_o    <= 1'b0;
        end else begin
            lock_q <= lock_d;
            prio_q <= prio_d;

            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;   // idle, or push and pop cancel
            endcase

            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            // A response with nothing outstanding (including late responses
            // to commands dropped by a reset) is discarded and flagged.
            if (mem.rvalid && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

    // NOTE: the owner storage has no reset; an entry is only ever read while
    // the count says it was written, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_mem[wr_ptr_q] <= sel;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Command towards sp_ram, zeroed whenever nothing is issued.
    assign mem.req   = issue;
    assign mem.addr  = issue ? (sel ? m1.addr  : m0.addr)  : '0;
    assign mem.we    = issue ? (sel ? m1.we    : m0.we)    : 1'b0;
    assign mem.wdata = issue ? (sel ? m1.wdata : m0.wdata) : '0;
    assign mem.be    = issue ? (sel ? m1.be    : m0.be)    : '0;

    // Grants pass through in the same cycle sp_ram grants.
    assign m0.gnt = push && !sel;
    assign m1.gnt = push &&  sel;

    // Responses go to the owner at the FIFO head; the other master sees 0.
    assign m0.rvalid = pop && !head_owner;
    assign m1.rvalid = pop &&  head_owner;
    assign m0.rdata  = (pop && !head_owner) ? mem.rdata : '0;
    assign m1.rdata  = (pop &&  head_owner) ? mem.rdata : '0;

endmodule
